rx_packet_arbiter: RTL
======================

Name: rx_packet_arbiter

Overview:
Round-robin arbiter that shares the single 128-bit accelerator packet-out stream between NUM_REQ packet producers, e.g. the NIC receive path, the message-matching engine and the Nios II mailbox. A message is one header beat followed by payload beats. Once a requester is granted, the arbiter keeps the grant for the whole message, so messages never interleave on the output. The output is valid-only with no backpressure, matching the downstream packet_out_packet/packet_out_valid port pair.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 128, packet beat width
LEN_W, 8, width of the payload-beat-count field in the header
LEN_LSB, 0, bit position of the count field's LSB in the header beat
ID_W, 2, grant id width; must equal clog2(NUM_REQ)

Ports:
clk_clk  in  1  system clock
reset_reset  in  1  asynchronous active-high reset
req_packet  in  NUM_REQ*DATA_W  requester beats; requester i occupies bits [i*DATA_W +: DATA_W]
req_valid  in  NUM_REQ  per-requester beat valid
req_ready  out  NUM_REQ  per-requester accept; a beat transfers when valid&&ready
packet_out_packet  out  DATA_W  registered output beat
packet_out_valid  out  1  output beat valid, one cycle per beat
grant_id  out  ID_W  index of the current or most recent grantee
busy  out  1  high while a message is owned

Behaviour:
- Reset (async, active-high):
  - state=IDLE, rr_ptr=0, remaining=0.
  - packet_out_valid=0, packet_out_packet=0, grant_id=0, busy=0, req_ready=0.
  - Reset asserted mid-message aborts the message immediately. Output valid drops asynchronously and the downstream sees a truncated message; no recovery beat is sent.
- States:
  - IDLE: req_ready all 0. If any req_valid is set, the winner is the first set bit searching upward from rr_ptr with wrap at NUM_REQ-1->0. On the next edge: grant_id=winner, busy=1, state=HEADER. If no valid, stay in IDLE.
  - HEADER: req_ready[grant_id]=1, all others 0. On accept: remaining=header[LEN_LSB +: LEN_W]. If remaining==0 (header-only message), go to IDLE; otherwise go to PAYLOAD.
  - PAYLOAD: req_ready[grant_id]=1. Each accept decrements remaining. An accept with remaining==1 is the last beat: go to IDLE.
  - On every return to IDLE: rr_ptr=(grant_id+1) mod NUM_REQ, busy=0.
- req_ready is a combinational decode of state and grant_id only. It never depends on req_valid.
- Output: each accepted beat appears on packet_out_packet with packet_out_valid=1 exactly one cycle after the accept edge. Latency is 1 cycle.
  - packet_out_packet holds its last value when valid=0.
  - Beat order is preserved.
- Throughput and bubbles:
  - One beat per cycle within a message.
  - IDLE costs exactly one arbitration cycle between messages.
  - Minimum output gap is 1 cycle, including back-to-back messages from the same requester.
- Stall: if the grantee drops req_valid mid-message, the grant and ready are held indefinitely and remaining is unchanged. There is no timeout; other requesters wait.
- Valid rising on other requesters during a message has no effect until IDLE.
- Count field: unsigned. Maximum message length is 2^LEN_W-1 payload beats plus the header. Bits outside the field are passed through untouched.
- grant_id holds its value in IDLE; it is updated only on a grant.

Test Plan:
- Single message: req1 sends header len=3 then 3 payload beats (0xA1..0xA3), valid continuous. Required response:
  - grant_id=1, busy=1 one cycle after valid.
  - Output shows header then 0xA1..0xA3 on 4 consecutive cycles, each 1 cycle after its accept.
  - busy=0 after the last beat.
  - rr_ptr=2.
- Fairness: all 4 requesters hold valid with header-only messages (len=0), starting from reset. Grants go 0,1,2,3,0, and each output beat is separated by exactly 1 idle cycle.
- No interleave: req0 sends len=2 while req2 raises valid mid-message. req2 gets req_ready=0 until req0's last beat, then is granted after one IDLE cycle.
- Stall: req3 sends len=4, drops valid for 5 cycles after payload beat 2, then resumes. req_ready[3] stays 1 throughout, no output during the gap, and all 5 beats arrive in order.
- Reset mid-message: assert reset_reset during payload beat 2 of a len=5 message. packet_out_valid=0 immediately, then after release: state IDLE, grant_id=0, rr_ptr=0, and a new req0 header is accepted normally.
- Max length: LEN_W=8, header len=255. Exactly 256 output beats, the grant is released after beat 256, and the remaining count never underflows.

Source files
------------

// File: rtl/rx_packet_arbiter.sv
// rx_packet_arbiter: round-robin arbiter that forwards whole messages (header beat
// plus payload beats) from NUM_REQ producers onto one valid-only packet-out stream.
module rx_packet_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 128,
    parameter int LEN_W   = 8,
    parameter int LEN_LSB = 0,
    parameter int ID_W    = 2
) (
    input  logic                      clk_clk,
    input  logic                      reset_reset,
    input  logic [NUM_REQ*DATA_W-1:0] req_packet,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         packet_out_packet,
    output logic                      packet_out_valid,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy
);

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD
    } state_t;

    localparam logic [ID_W:0] NUM_REQ_W = (ID_W + 1)'(NUM_REQ);

    state_t           state;
    logic [ID_W-1:0]  rr_ptr;
    logic [LEN_W-1:0] remaining;

    logic [NUM_REQ-1:0] rot_valid;
    logic               win_found;
    logic [ID_W:0]      win_sum;
    logic [ID_W-1:0]    win_id;
    logic [ID_W:0]      next_ptr;
    logic [DATA_W-1:0]  sel_beat;
    logic               sel_valid;
    logic               accept;
    logic [LEN_W-1:0]   hdr_len;

    // Rotating the request vector by rr_ptr turns the wrapped search into a
    // plain lowest-set-bit search; the offset is added back afterwards.
    assign rot_valid = NUM_REQ'({req_valid, req_valid} >> rr_ptr);

    always_comb begin
        // NOTE: every always_comb output is given a default first so no path infers a latch.
        win_found = 1'b0;
        win_sum   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                win_found = 1'b1;
                win_sum   = {1'b0, rr_ptr} + (ID_W + 1)'(k);
            end
        end
        if (win_sum >= NUM_REQ_W) begin
            win_sum = win_sum - NUM_REQ_W;
        end
        win_id = win_sum[ID_W-1:0];
    end

    // Ready depends only on state and grant_id, never on req_valid.
    always_comb begin
        req_ready = '0;
        sel_beat  = '0;
        sel_valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_id == ID_W'(k)) begin
                req_ready[k] = (state != IDLE);
                sel_beat     = req_packet[k*DATA_W +: DATA_W];
                sel_valid    = req_valid[k];
            end
        end
    end

    always_comb begin
        next_ptr = {1'b0, grant_id} + (ID_W + 1)'(1);
        if (next_ptr >= NUM_REQ_W) begin
            next_ptr = '0;
        end
    end

    assign accept  = (state != IDLE) && sel_valid;
    assign hdr_len = sel_beat[LEN_LSB +: LEN_W];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state             <= IDLE;
            rr_ptr            <= '0;
            remaining         <= '0;
            grant_id          <= '0;
            busy              <= 1'b0;
            packet_out_valid  <= 1'b0;
            packet_out_packet <= '0;
        end else begin
            packet_out_valid <= accept;
            if (accept) begin
                packet_out_packet <= sel_beat;
            end

            case (state)
                IDLE: begin
                    if (win_found) begin
                        grant_id <= win_id;
                        busy     <= 1'b1;
                        state    <= HEADER;
                    end
                end
                HEADER: begin
                    if (accept) begin
                        remaining <= hdr_len;
                        if (hdr_len == '0) begin
                            state  <= IDLE;
                            busy   <= 1'b0;
                            rr_ptr <= next_ptr[ID_W-1:0];
                        end else begin
                            state <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    // A stalled grantee simply leaves remaining untouched.
                    if (accept) begin
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state  <= IDLE;
                            busy   <= 1'b0;
                            rr_ptr <= next_ptr[ID_W-1:0];
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
